// File: rtl/fpmult_unpack_stage.sv
// Front-end of the FP multiplier: unpacks two IEEE-754 singles, classifies special
// operands and presents the result through a registered valid/ready stage with a skid slot.
module fpmult_unpack_stage #(
  parameter int unsigned FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Sp,
  output logic [7:0]  Ea,
  output logic [7:0]  Eb,
  output logic [23:0] Ma,
  output logic [23:0] Mb,
  output logic        Zp,
  output logic [4:0]  InputExc
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned EXC_W  = 5;

  typedef struct packed {
    logic              sp;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [MANT_W-1:0] ma;
    logic [MANT_W-1:0] mb;
    logic              zp;
    logic [EXC_W-1:0]  exc;
  } beat_t;

  typedef struct packed {
    logic              nan;
    logic              inf;
    logic              zero;
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
  } opnd_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Split one operand and apply the denormal policy (flush to zero, or keep with exponent 1).
  function automatic opnd_t classify(input logic [31:0] x);
    opnd_t             o;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;
    exp_f  = x[30:23];
    frac   = x[22:0];
    o.nan  = (&exp_f) & (|frac);
    o.inf  = (&exp_f) & ~(|frac);
    o.zero = ~(|exp_f) & ~(|frac);
    o.e    = exp_f;
    o.m    = {(|exp_f), frac};
    if (~(|exp_f) && (|frac)) begin
      if (FLUSH_DENORM != 0) begin
        o.e    = '0;
        o.m    = '0;
        o.zero = 1'b1;
      end else begin
        o.e = EXP_W'(1);
      end
    end
    return o;
  endfunction

  opnd_t  w_oa;
  opnd_t  w_ob;
  beat_t  w_dec;
  beat_t  w_main_nxt;
  beat_t  w_skid_nxt;
  state_t w_state_nxt;
  logic   w_acc;
  logic   w_pop;

  beat_t  r_main;
  beat_t  r_skid;
  state_t r_state;
  logic   r_out_valid;
  logic   r_in_ready;

  always_comb begin
    w_oa      = classify(a);
    w_ob      = classify(b);
    w_dec.sp  = a[31] ^ b[31];
    w_dec.ea  = w_oa.e;
    w_dec.eb  = w_ob.e;
    w_dec.ma  = w_oa.m;
    w_dec.mb  = w_ob.m;
    w_dec.zp  = w_oa.zero | w_ob.zero;
    w_dec.exc = {(w_oa.nan | w_ob.nan | w_oa.inf | w_ob.inf),
                 w_oa.nan, w_ob.nan, w_oa.inf, w_ob.inf};
  end

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  // Occupancy FSM: main register plus one skid slot, strictly FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_main_nxt  = w_dec;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_pop && w_acc) begin
          w_main_nxt = w_dec;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_acc) begin
          w_skid_nxt  = w_dec;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Sp        = r_main.sp;
  assign Ea        = r_main.ea;
  assign Eb        = r_main.eb;
  assign Ma        = r_main.ma;
  assign Mb        = r_main.mb;
  assign Zp        = r_main.zp;
  assign InputExc  = r_main.exc;

endmodule

// File: tb/tb_fpmult_unpack_stage.sv
// Bench for fpmult_unpack_stage: both denormal policies side by side against a
// 2-deep FIFO reference model plus directed operand cases.
module tb_fpmult_unpack_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic        f_in_ready, f_out_valid, f_Sp, f_Zp;
  logic [7:0]  f_Ea, f_Eb;
  logic [23:0] f_Ma, f_Mb;
  logic [4:0]  f_Exc;
  logic        k_in_ready, k_out_valid, k_Sp, k_Zp;
  logic [7:0]  k_Ea, k_Eb;
  logic [23:0] k_Ma, k_Mb;
  logic [4:0]  k_Exc;
  logic [70:0] f_data;
  logic [70:0] k_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q[$];
  bit          dir_en = 1'b0;
  logic [70:0] dir_e1;
  logic [70:0] dir_e0;

  always #5 clk = ~clk;

  fpmult_unpack_stage #(.FLUSH_DENORM(1)) u_flush (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(f_in_ready),
    .out_valid(f_out_valid), .out_ready(out_ready), .Sp(f_Sp), .Ea(f_Ea), .Eb(f_Eb),
    .Ma(f_Ma), .Mb(f_Mb), .Zp(f_Zp), .InputExc(f_Exc)
  );

  fpmult_unpack_stage #(.FLUSH_DENORM(0)) u_keep (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(k_in_ready),
    .out_valid(k_out_valid), .out_ready(out_ready), .Sp(k_Sp), .Ea(k_Ea), .Eb(k_Eb),
    .Ma(k_Ma), .Mb(k_Mb), .Zp(k_Zp), .InputExc(k_Exc)
  );

  assign f_data = {f_Sp, f_Ea, f_Eb, f_Ma, f_Mb, f_Zp, f_Exc};
  assign k_data = {k_Sp, k_Ea, k_Eb, k_Ma, k_Mb, k_Zp, k_Exc};

  task automatic chk(input string tag, input logic [70:0] got, input logic [70:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [31:0] x, input bit flush,
                                 output logic [7:0] e, output logic [23:0] m,
                                 output logic nan, output logic inf, output logic zero);
    int unsigned ex;
    int unsigned fr;
    ex   = 32'(x[30:23]);
    fr   = 32'(x[22:0]);
    nan  = (ex == 255) && (fr != 0);
    inf  = (ex == 255) && (fr == 0);
    zero = 1'b0;
    if (ex == 0 && fr == 0) begin
      e = 8'd0; m = 24'd0; zero = 1'b1;
    end else if (ex == 0) begin
      if (flush) begin
        e = 8'd0; m = 24'd0; zero = 1'b1;
      end else begin
        e = 8'd1; m = 24'(fr);
      end
    end else begin
      e = 8'(ex);
      m = 24'(fr + 32'h0080_0000);
    end
  endfunction

  function automatic logic [70:0] ref_unpack(input logic [31:0] x, input logic [31:0] y,
                                             input bit flush);
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        na, ia, za, nb, ib, zb;
    ref_op(x, flush, ea, ma, na, ia, za);
    ref_op(y, flush, eb, mb, nb, ib, zb);
    return {x[31] ^ y[31], ea, eb, ma, mb, za | zb, (na | nb | ia | ib), na, nb, ia, ib};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:0] = 31'd0;
      1: r[30:23] = 8'h00;
      2: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      3: r[30:23] = 8'hFF;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: check DUT against the model at negedge, then advance the model at posedge.
  task automatic step();
    bit acc;
    bit pop;
    @(negedge clk);
    chk("out_valid_flush", 71'(f_out_valid), 71'(q.size() > 0));
    chk("out_valid_keep",  71'(k_out_valid), 71'(q.size() > 0));
    chk("in_ready_flush",  71'(f_in_ready),  71'(q.size() < 2));
    chk("in_ready_keep",   71'(k_in_ready),  71'(q.size() < 2));
    if (q.size() > 0) begin
      chk("data_flush", f_data, ref_unpack(q[0][63:32], q[0][31:0], 1'b1));
      chk("data_keep",  k_data, ref_unpack(q[0][63:32], q[0][31:0], 1'b0));
    end
    if (dir_en) begin
      chk("directed_flush", f_data, dir_e1);
      chk("directed_keep",  k_data, dir_e0);
      dir_en = 1'b0;
    end
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({a, b});
    end
    #1;
  endtask

  task automatic directed(input logic [31:0] xa, input logic [31:0] xb,
                          input logic [70:0] e1, input logic [70:0] e0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    a = xa; b = xb; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom;
    dir_e1 = e1; dir_e0 = e0; dir_en = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_data_flush", f_data, 71'd0);
    chk("reset_data_keep",  k_data, 71'd0);
    chk("reset_valid",      71'({f_out_valid, k_out_valid}), 71'd0);
    chk("reset_ready",      71'({f_in_ready, k_in_ready}), 71'd3);

    directed(32'h3F80_0000, 32'h4000_0000,
             {1'b0, 8'h7F, 8'h80, 24'h80_0000, 24'h80_0000, 1'b0, 5'b00000},
             {1'b0, 8'h7F, 8'h80, 24'h80_0000, 24'h80_0000, 1'b0, 5'b00000});
    directed(32'h7FC0_0000, 32'h3F80_0000,
             {1'b0, 8'hFF, 8'h7F, 24'hC0_0000, 24'h80_0000, 1'b0, 5'b11000},
             {1'b0, 8'hFF, 8'h7F, 24'hC0_0000, 24'h80_0000, 1'b0, 5'b11000});
    directed(32'h7F80_0000, 32'hFF80_0000,
             {1'b1, 8'hFF, 8'hFF, 24'h80_0000, 24'h80_0000, 1'b0, 5'b10011},
             {1'b1, 8'hFF, 8'hFF, 24'h80_0000, 24'h80_0000, 1'b0, 5'b10011});
    directed(32'h0000_0001, 32'hC040_0000,
             {1'b1, 8'h00, 8'h80, 24'h00_0000, 24'hC0_0000, 1'b1, 5'b00000},
             {1'b1, 8'h01, 8'h80, 24'h00_0001, 24'hC0_0000, 1'b0, 5'b00000});

    // Backpressure: two beats fill the stage, the third is held off.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = rand_op(); b = rand_op();
      step();
    end
    chk("stall_in_ready", 71'(f_in_ready), 71'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = 1'b0;
    end

    // Back-to-back streaming.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = rand_op(); b = rand_op();
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Reset while full, then one fresh beat.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand_op(); b = rand_op();
      step();
    end
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    a = rand_op(); b = rand_op(); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      a = rand_op(); b = rand_op();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
